// File: rtl/e_arbiter16_pkg.sv
// rtl/e_arbiter16_pkg.sv - shared constants, state encoding and search helper for e_arbiter16
// Purpose: package e_arb_pkg, imported by the arbiter, its interface and the bench.
// Contents: N_REQ/IDX_W sizes, IDLE/BUSY/GAP state codes, state enum, first-set helper.
package e_arb_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_BUSY = BUSY,
    ST_GAP  = GAP
  } state_e;

  // Lowest set bit of v; 0 when v is empty (callers only use it with v != 0).
  function automatic logic [IDX_W-1:0] first_set(input logic [N_REQ-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/e_arbiter16_if.sv
// rtl/e_arbiter16_if.sv - request/grant bundle between requester agents and e_arbiter16
// Purpose: groups the arbiter handshake signals.
// Signals: req[15:0], done (requester side); grant[15:0], grant_idx[3:0], busy, timeout (arbiter side).
// Modports: master = requester side, slave = arbiter side.
interface e_arbiter16_if;
  import e_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             busy;
  logic             timeout;

  modport master (
    output req, done,
    input  grant, grant_idx, busy, timeout
  );

  modport slave (
    input  req, done,
    output grant, grant_idx, busy, timeout
  );

endinterface

// File: rtl/e_decoder4to16.sv
// rtl/e_decoder4to16.sv - 4-to-16 binary to one-hot decoder
// Purpose: combinational decode of a 4-bit index into a 16-bit one-hot vector.
// Ports: idx[3:0] in, onehot[15:0] out.
module e_decoder4to16 (
  input  logic [3:0]  idx,
  output logic [15:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/e_arbiter16.sv
// rtl/e_arbiter16.sv - 16-way round-robin arbiter with hold limit and registered one-hot grant
// Purpose: grants one of 16 requesters, holds until done/request drop/MAX_HOLD, then one dead cycle.
// Ports: clk, rst_n (async active-low), bus (e_arbiter16_if.slave: req, done in; grant, grant_idx, busy, timeout out).
module e_arbiter16
  import e_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  e_arbiter16_if.slave   bus
);

  localparam int                HCNT_W   = $clog2(MAX_HOLD + 1);
  localparam logic [HCNT_W-1:0] HOLD_LIM = HCNT_W'(MAX_HOLD);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;

  logic [N_REQ-1:0]  rotated;
  logic [IDX_W-1:0]  win_idx;
  logic              at_limit;
  logic              owner_req;
  logic              release_now;
  logic              forced;
  logic [N_REQ-1:0]  dec_onehot;

  // Rotate so that bit 0 is the requester at ptr; the 4-bit index sum wraps mod 16.
  always_comb begin
    rotated = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rotated[i] = bus.req[ptr_q + IDX_W'(i)];
    end
  end

  assign win_idx = first_set(rotated) + ptr_q;

  assign at_limit    = (hcnt_q == HOLD_LIM);
  assign owner_req   = bus.req[idx_q];
  assign release_now = bus.done || !owner_req || at_limit;
  // Only a limit hit with the owner still requesting and not done is a forced release.
  assign forced      = at_limit && !bus.done && owner_req;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hcnt_d    = hcnt_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          idx_d   = win_idx;
          hcnt_d  = HCNT_W'(1);
          busy_d  = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (release_now) begin
          ptr_d     = idx_q + IDX_W'(1);
          idx_d     = '0;
          hcnt_d    = '0;
          busy_d    = 1'b0;
          timeout_d = forced;
          state_d   = ST_GAP;
        end else begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        idx_d   = '0;
        hcnt_d  = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      hcnt_q    <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hcnt_q    <= hcnt_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  e_decoder4to16 u_dec (
    .idx    (idx_q),
    .onehot (dec_onehot)
  );

  // idx_q and busy_q are both flops, so the gated decode is glitch-free without another register.
  assign bus.grant     = dec_onehot & {N_REQ{busy_q}};
  assign bus.grant_idx = idx_q;
  assign bus.busy      = busy_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_e_arbiter16.sv
// tb/tb_e_arbiter16.sv - directed self-checking bench for e_arbiter16 (MAX_HOLD = 4)
module tb_e_arbiter16;
  import e_arb_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  e_arbiter16_if bus ();

  e_arbiter16 #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.done = 1'b0;
    #2;
    checks++; if (bus.grant !== 16'h0000) begin failures++; $display("FAIL reset_grant: got %h exp %h", bus.grant, 16'h0000); end
    checks++; if (bus.grant_idx !== 4'd0) begin failures++; $display("FAIL reset_idx: got %0d exp 0", bus.grant_idx); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
    checks++; if (bus.timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b exp 0", bus.timeout); end
    tick();
    rst_n   = 1'b1;
    bus.req = 16'hFFFF;
    tick();
    checks++; if (bus.grant !== 16'h0001) begin failures++; $display("FAIL reset_first_grant: got %h exp %h", bus.grant, 16'h0001); end
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.grant !== 16'h0000) begin failures++; $display("FAIL midbusy_grant: got %h exp %h", bus.grant, 16'h0000); end
    checks++; if (bus.grant_idx !== 4'd0) begin failures++; $display("FAIL midbusy_idx: got %0d exp 0", bus.grant_idx); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midbusy_busy: got %b exp 0", bus.busy); end
    checks++; if (bus.timeout !== 1'b0) begin failures++; $display("FAIL midbusy_timeout: got %b exp 0", bus.timeout); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus.grant !== 16'h0001) begin failures++; $display("FAIL after_reset_grant: got %h exp %h", bus.grant, 16'h0001); end
    bus.req = '0;
    tick();
    tick();
  endtask

  task automatic test_single();
    bus.req = 16'h0010;
    #1;
    checks++; if (bus.grant !== 16'h0000) begin failures++; $display("FAIL single_no_comb: got %h exp %h", bus.grant, 16'h0000); end
    tick();
    checks++; if (bus.grant !== 16'h0010) begin failures++; $display("FAIL single_grant: got %h exp %h", bus.grant, 16'h0010); end
    checks++; if (bus.grant_idx !== 4'd4) begin failures++; $display("FAIL single_idx: got %0d exp 4", bus.grant_idx); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b exp 1", bus.busy); end
    bus.done = 1'b1;
    tick();
    checks++; if (bus.grant !== 16'h0000) begin failures++; $display("FAIL single_gap_grant: got %h exp %h", bus.grant, 16'h0000); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL single_gap_busy: got %b exp 0", bus.busy); end
    checks++; if (bus.timeout !== 1'b0) begin failures++; $display("FAIL single_gap_timeout: got %b exp 0", bus.timeout); end
    bus.done = 1'b0;
    tick();
    checks++; if (bus.grant !== 16'h0000) begin failures++; $display("FAIL single_idle_grant: got %h exp %h", bus.grant, 16'h0000); end
    tick();
    checks++; if (bus.grant !== 16'h0010) begin failures++; $display("FAIL single_regrant: got %h exp %h", bus.grant, 16'h0010); end
    bus.req = '0;
    tick();
    tick();
  endtask

  task automatic test_rotation();
    logic [15:0] exp_seq [4];
    exp_seq[0] = 16'h0001;
    exp_seq[1] = 16'h8000;
    exp_seq[2] = 16'h0001;
    exp_seq[3] = 16'h8000;
    rst_n = 1'b0;
    #2;
    rst_n   = 1'b1;
    bus.req = 16'h8001;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (bus.grant !== exp_seq[k]) begin failures++; $display("FAIL rotation_grant%0d: got %h exp %h", k, bus.grant, exp_seq[k]); end
      bus.done = 1'b1;
      tick();
      checks++; if (bus.grant !== 16'h0000) begin failures++; $display("FAIL rotation_gap%0d: got %h exp %h", k, bus.grant, 16'h0000); end
      bus.done = 1'b0;
      tick();
    end
    bus.req = '0;
  endtask

  task automatic test_timeout();
    bus.req = 16'h0006;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++; if (bus.grant !== 16'h0002) begin failures++; $display("FAIL timeout_hold%0d: got %h exp %h", c, bus.grant, 16'h0002); end
      checks++; if (bus.timeout !== 1'b0) begin failures++; $display("FAIL timeout_early%0d: got %b exp 0", c, bus.timeout); end
    end
    tick();
    checks++; if (bus.grant !== 16'h0000) begin failures++; $display("FAIL timeout_release: got %h exp %h", bus.grant, 16'h0000); end
    checks++; if (bus.timeout !== 1'b1) begin failures++; $display("FAIL timeout_pulse: got %b exp 1", bus.timeout); end
    tick();
    checks++; if (bus.timeout !== 1'b0) begin failures++; $display("FAIL timeout_one_cycle: got %b exp 0", bus.timeout); end
    tick();
    checks++; if (bus.grant !== 16'h0004) begin failures++; $display("FAIL timeout_next_grant: got %h exp %h", bus.grant, 16'h0004); end
    checks++; if (bus.grant_idx !== 4'd2) begin failures++; $display("FAIL timeout_next_idx: got %0d exp 2", bus.grant_idx); end
    bus.req = '0;
    tick();
    tick();
  endtask

  task automatic test_req_drop();
    bus.req = 16'h0008;
    tick();
    checks++; if (bus.grant_idx !== 4'd3) begin failures++; $display("FAIL drop_idx: got %0d exp 3", bus.grant_idx); end
    bus.req = '0;
    tick();
    checks++; if (bus.grant !== 16'h0000) begin failures++; $display("FAIL drop_release: got %h exp %h", bus.grant, 16'h0000); end
    checks++; if (bus.timeout !== 1'b0) begin failures++; $display("FAIL drop_timeout: got %b exp 0", bus.timeout); end
    tick();
    bus.req = 16'h0030;
    tick();
    checks++; if (bus.grant !== 16'h0010) begin failures++; $display("FAIL drop_ptr4: got %h exp %h", bus.grant, 16'h0010); end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req  = '0;
    tick();
  endtask

  task automatic test_done_limit();
    bus.req = 16'h0040;
    for (int c = 1; c <= 4; c++) tick();
    checks++; if (bus.grant !== 16'h0040) begin failures++; $display("FAIL limit_hold: got %h exp %h", bus.grant, 16'h0040); end
    bus.done = 1'b1;
    tick();
    checks++; if (bus.grant !== 16'h0000) begin failures++; $display("FAIL limit_release: got %h exp %h", bus.grant, 16'h0000); end
    checks++; if (bus.timeout !== 1'b0) begin failures++; $display("FAIL limit_timeout: got %b exp 0", bus.timeout); end
    bus.done = 1'b0;
    bus.req  = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    bus.req = 16'hFFFF;
    tick();
    checks++; if (bus.grant !== 16'h0080) begin failures++; $display("FAIL b2b_first: got %h exp %h", bus.grant, 16'h0080); end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
    checks++; if (bus.grant !== 16'h0000) begin failures++; $display("FAIL b2b_idle: got %h exp %h", bus.grant, 16'h0000); end
    tick();
    checks++; if (bus.grant !== 16'h0100) begin failures++; $display("FAIL b2b_second: got %h exp %h", bus.grant, 16'h0100); end
    checks++; if (bus.grant_idx !== 4'd8) begin failures++; $display("FAIL b2b_idx: got %0d exp 8", bus.grant_idx); end
    bus.req = '0;
    tick();
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_req_drop();
    test_done_limit();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/e_arbiter16.md
# e_arbiter16

Round-robin arbiter that shares one resource among 16 requesters and drives a registered one-hot grant vector. The grant index is decoded to one-hot through the team's 4-to-16 decoder. A grant is held until the winner releases it, drops its request, or overruns a hold limit. The block sits between requester agents and any single-owner resource (bus, memory port, shared datapath) that needs a one-hot select.

## Interface
- MAX_HOLD, default 8, maximum consecutive cycles one grant may be held (≥1).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  16  request vector; bit i = requester i wants the resource.
- done  input  1  current owner releases the resource (sampled only in BUSY).
- grant  output  16  registered one-hot grant; all-zero when no owner.
- grant_idx  output  4  binary index of the current owner; 0 when no owner.
- busy  output  1  high while a grant is active.
- timeout  output  1  one-cycle pulse: the previous grant was force-released at MAX_HOLD.

## Operation
- States: IDLE, BUSY, GAP (2-bit encoding).
- Internal registers: 4-bit priority pointer ptr, hold counter hcnt of width $clog2(MAX_HOLD+1).
- **IDLE:**
  - If req != 0, select the first set bit scanning cyclically from ptr upward: ptr, ptr+1, …, 15, 0, …, ptr-1.
  - Load grant_idx with that index and set hcnt=1.
  - Go to BUSY.
  - If req == 0, stay in IDLE.
- **BUSY:**
  - grant = one-hot(grant_idx) and busy = 1.
  - Release occurs on any of:
    - done = 1,
    - req[grant_idx] = 0,
    - hcnt == MAX_HOLD.
  - If none of these holds, hcnt increments.
  - On release:
    - go to GAP,
    - set ptr = grant_idx + 1 (mod 16, so 15 wraps to 0),
    - clear grant and busy at the same edge.
- **GAP:**
  - Exactly one dead cycle: grant = 0, busy = 0.
  - timeout = 1 only if the release was forced by hcnt == MAX_HOLD while done = 0 and req[grant_idx] = 1.
  - Next state is IDLE unconditionally.
- Simultaneous events:
  - done together with the hold limit counts as a normal release (no timeout).
  - A request drop together with done counts as a normal release.
  - Requests from other requesters during BUSY or GAP are ignored until IDLE.
- Requests not selected are not latched; a requester must keep req high until it is granted.

## Timing
- Reset (async, rst_n low) forces: state = IDLE, ptr = 0, hcnt = 0, grant = 0, grant_idx = 0, busy = 0, timeout = 0.
  - Outputs go to these values immediately, without waiting for a clock edge.
- Reset mid-BUSY drops the grant asynchronously.
- Grant latency:
  - A req seen at edge k in IDLE produces grant/busy valid after edge k.
  - The minimum from a request to a new owner is 1 cycle.
- Release latency:
  - done seen at edge k in BUSY clears grant after edge k.
  - IDLE follows after edge k+1.
  - The earliest next grant appears after edge k+2.
- Hold duration: the grant is held at most MAX_HOLD cycles. With MAX_HOLD = 1, every grant lasts exactly 1 cycle.
- Back-to-back throughput: at most one grant per 3 cycles (BUSY ≥ 1, GAP 1, IDLE 1).
- All outputs are registered; there is no combinational path from req or done to any output.

## Structure
- Package e_arb_pkg:
  - state localparams IDLE/BUSY/GAP,
  - N_REQ = 16,
  - IDX_W = 4.
- Sub-module: instantiate the existing e_decoder4to16 to drive grant from grant_idx.
  - Gate its output to zero when busy = 0.
  - Because grant_idx and busy are both registered, the one-hot grant needs no extra output flop.
- The cyclic first-set search is combinational logic inside the arbiter. Use a rotate-by-ptr, priority-encode, then add-ptr structure.

## Test plan
- Reset: drive rst_n = 0 mid-BUSY, with req = 16'hFFFF.
  - Required: grant = 0, grant_idx = 0, busy = 0, timeout = 0 immediately.
  - Required after release: the first grant is 16'h0001.
- Single request: req = 16'h0010.
  - Required: grant = 16'h0010 and grant_idx = 4 one cycle later.
  - Required on done: grant = 0 for one GAP cycle, then IDLE.
- Rotation: req held at 16'h8001, done pulsed each grant.
  - Required: grant sequence 16'h0001, 16'h8000, 16'h0001, 16'h8000.
  - Required: ptr wraps from 15 to 0.
- Timeout: MAX_HOLD = 4, req = 16'h0006 held, done = 0.
  - Required: grant = 16'h0002 for exactly 4 cycles, then timeout = 1 for one cycle.
  - Required: the next grant is 16'h0004.
- Request drop: while granted to index 3, deassert req[3].
  - Required: release at the next edge, timeout = 0, ptr = 4.
- Done with limit: assert done on the cycle where hcnt == MAX_HOLD.
  - Required: normal release and timeout stays 0.
